// File: rtl/nlp_seq_pkg.sv
// rtl/nlp_seq_pkg.sv - shared constants for the NLP-16AF instruction sequencer (optional IRQ states under NLP_SEQ_IRQ_EN)
package nlp_seq_pkg;

    typedef logic [4:0] state_t;

    // FSM state encodings; IRQ states are only reachable when NLP_SEQ_IRQ_EN is defined
    localparam state_t ST_IF1   = 5'd0;
    localparam state_t ST_D1    = 5'd1;
    localparam state_t ST_IF2   = 5'd2;
    localparam state_t ST_D2    = 5'd3;
    localparam state_t ST_IF3   = 5'd4;
    localparam state_t ST_D3    = 5'd5;
    localparam state_t ST_PUSH1 = 5'd6;
    localparam state_t ST_PUSH2 = 5'd7;
    localparam state_t ST_POP1  = 5'd8;
    localparam state_t ST_POP2  = 5'd9;
    localparam state_t ST_EXE   = 5'd10;
    localparam state_t ST_RD    = 5'd11;
    localparam state_t ST_WR    = 5'd12;
    localparam state_t ST_ERR   = 5'd13;
    localparam state_t ST_IRQ1  = 5'd14;
    localparam state_t ST_IRQ2  = 5'd15;
    localparam state_t ST_IRQ3  = 5'd16;

    // ALU opcodes
    localparam logic [5:0] ALU_MOV = 6'h00;
    localparam logic [5:0] ALU_DEC = 6'h08;
    localparam logic [5:0] ALU_INC = 6'h1B;

    // Register file addresses
    localparam logic [3:0] RA_IR1  = 4'h1;
    localparam logic [3:0] RA_FLAG = 4'h2;
    localparam logic [3:0] RA_IR3  = 4'h3;
    localparam logic [3:0] RA_IR2  = 4'h4;
    localparam logic [3:0] RA_IRQV = 4'hC;
    localparam logic [3:0] RA_IP   = 4'hD;
    localparam logic [3:0] RA_SP   = 4'hE;

    // Instruction classes (top nibble of IR1)
    localparam logic [3:0] INST_LOAD  = 4'h8;
    localparam logic [3:0] INST_STORE = 4'h9;
    localparam logic [3:0] INST_CALL  = 4'hB;
    localparam logic [3:0] INST_POP   = 4'hC;
    localparam logic [3:0] INST_PUSH  = 4'hD;

    // Base states that hold a memory strobe until acknowledged
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_IF1) || (s == ST_IF2) || (s == ST_IF3) || (s == ST_PUSH2) ||
               (s == ST_POP1) || (s == ST_RD) || (s == ST_WR);
    endfunction

endpackage

// File: rtl/nlp_seq_wait_timer.sv
// rtl/nlp_seq_wait_timer.sv - per-state memory wait counter with timeout detect
module nlp_seq_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clear_i,
    input  logic count_i,
    input  logic ack_i,
    output logic timeout_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Count unacknowledged cycles; any state change restarts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (count_i && !ack_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // This cycle would be the MAX_WAIT-th wait; an ack in the same cycle suppresses it
    assign timeout_o = count_i && !ack_i && (cnt_q == 8'(MAX_WAIT - 1));

    // Counter register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nlp_sequencer.sv
// rtl/nlp_sequencer.sv - NLP-16AF fetch/execute sequencer with memory handshake (IRQ entry under NLP_SEQ_IRQ_EN)
module nlp_sequencer
    import nlp_seq_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int OP_W     = 6,
    parameter int MAX_WAIT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_ir1,
    input  logic [DATA_W-1:0] i_ir2,
`ifdef NLP_SEQ_IRQ_EN
    input  logic              i_irq,
    output logic              o_irq_ack,
`endif
    input  logic              i_mem_ack,
    output logic [4:0]        o_state,
    output logic              o_err,
    output logic [OP_W-1:0]   o_alu_op,
    output logic [REG_AW-1:0] o_s1,
    output logic [REG_AW-1:0] o_s2,
    output logic [REG_AW-1:0] o_dest,
    output logic              o_mem_rd,
    output logic              o_mem_wr
);

    localparam logic [REG_AW-1:0] ZR_A  = '1;
    localparam logic [REG_AW-1:0] IR1_A = REG_AW'(RA_IR1);
    localparam logic [REG_AW-1:0] IR2_A = REG_AW'(RA_IR2);
    localparam logic [REG_AW-1:0] IR3_A = REG_AW'(RA_IR3);
    localparam logic [REG_AW-1:0] IP_A  = REG_AW'(RA_IP);
    localparam logic [REG_AW-1:0] SP_A  = REG_AW'(RA_SP);

    state_t state_q;
    state_t state_d;
    logic   err_q;
    logic   mem_state;
    logic   timeout;

    logic [3:0]        inst;
    logic              op_class;
    logic [OP_W-1:0]   dec_alu;
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic [REG_AW-1:0] ra3;
    logic              im16;

    logic [OP_W-1:0]   alu_c;
    logic [REG_AW-1:0] s1_c;
    logic [REG_AW-1:0] s2_c;
    logic [REG_AW-1:0] dest_c;
    logic              rd_c;
    logic              wr_c;

    // Only selected instruction fields feed the decoder
    logic unused_ir;
    assign unused_ir = ^{i_ir1, i_ir2};

    assign inst     = i_ir1[DATA_W-1 -: 4];
    assign op_class = (inst[3:2] == 2'b00);
    assign dec_alu  = op_class ? OP_W'(i_ir1[13:8]) : OP_W'({2'b00, i_ir1[11:8]});
    assign ra1      = i_ir1[REG_AW-1:0];
    assign ra2      = REG_AW'(i_ir2[15:12]);
    assign ra3      = REG_AW'(i_ir2[11:8]);
    assign im16     = (ra2 == IR3_A) || (ra3 == IR3_A);

`ifdef NLP_SEQ_IRQ_EN
    assign mem_state = is_mem_state(state_q) || (state_q == ST_IRQ2);
`else
    assign mem_state = is_mem_state(state_q);
`endif

    nlp_seq_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .clear_i   (state_d != state_q),
        .count_i   (mem_state),
        .ack_i     (i_mem_ack),
        .timeout_o (timeout)
    );

    // Next state: successor per state, then memory states hold until ack or time out
    always_comb begin
        state_d = ST_ERR;
        case (state_q)
            ST_IF1:   state_d = ST_D1;
            ST_D1: begin
                if (inst == INST_PUSH || inst == INST_CALL) state_d = ST_PUSH1;
                else if (inst == INST_POP)                  state_d = ST_POP1;
                else                                        state_d = ST_IF2;
            end
            ST_IF2:   state_d = ST_D2;
            ST_D2:    state_d = im16 ? ST_IF3 : ST_EXE;
            ST_IF3:   state_d = ST_D3;
            ST_D3:    state_d = ST_EXE;
            ST_PUSH1: state_d = ST_PUSH2;
            ST_PUSH2: state_d = (inst == INST_CALL) ? ST_IF2 : ST_IF1;
            ST_POP1:  state_d = ST_POP2;
            ST_POP2:  state_d = ST_IF1;
            ST_EXE: begin
                if (inst == INST_LOAD)       state_d = ST_RD;
                else if (inst == INST_STORE) state_d = ST_WR;
                else                         state_d = ST_IF1;
            end
            ST_RD:    state_d = ST_IF1;
            ST_WR:    state_d = ST_IF1;
            ST_ERR:   state_d = ST_ERR;
`ifdef NLP_SEQ_IRQ_EN
            ST_IRQ1:  state_d = ST_IRQ2;
            ST_IRQ2:  state_d = ST_IRQ3;
            ST_IRQ3:  state_d = ST_IF1;
`endif
            default:  state_d = ST_ERR;
        endcase
        if (mem_state && !i_mem_ack) begin
            state_d = timeout ? ST_ERR : state_q;
        end
`ifdef NLP_SEQ_IRQ_EN
        if (state_q == ST_IF1 && i_irq && !i_mem_ack) begin
            state_d = ST_IRQ1;
        end
`endif
    end

    // Datapath controls decoded from the current state and instruction words
    always_comb begin
        alu_c  = OP_W'(ALU_MOV);
        s1_c   = ZR_A;
        s2_c   = ZR_A;
        dest_c = ZR_A;
        rd_c   = 1'b0;
        wr_c   = 1'b0;
`ifdef NLP_SEQ_IRQ_EN
        o_irq_ack = 1'b0;
`endif
        case (state_q)
            ST_IF1: begin rd_c = 1'b1; dest_c = IR1_A; end
            ST_IF2: begin rd_c = 1'b1; dest_c = IR2_A; end
            ST_IF3: begin rd_c = 1'b1; dest_c = IR3_A; end
            ST_D1, ST_D2, ST_D3: begin
                alu_c = OP_W'(ALU_INC); s1_c = IP_A; dest_c = IP_A;
            end
            ST_PUSH1: begin alu_c = OP_W'(ALU_DEC); s1_c = SP_A; dest_c = SP_A; end
            ST_PUSH2: begin wr_c = 1'b1; s1_c = ra1; end
            ST_POP1:  begin rd_c = 1'b1; dest_c = ra1; end
            ST_POP2:  begin alu_c = OP_W'(ALU_INC); s1_c = SP_A; dest_c = SP_A; end
            ST_EXE: begin
                alu_c = dec_alu; s1_c = ra2; s2_c = ra3; dest_c = ra1;
            end
            ST_RD:    begin rd_c = 1'b1; dest_c = ra1; end
            ST_WR:    begin wr_c = 1'b1; s1_c = ra1; end
`ifdef NLP_SEQ_IRQ_EN
            ST_IRQ1:  begin alu_c = OP_W'(ALU_DEC); s1_c = SP_A; dest_c = SP_A; end
            ST_IRQ2:  begin wr_c = 1'b1; s1_c = IP_A; end
            ST_IRQ3: begin
                s1_c = REG_AW'(RA_IRQV); dest_c = IP_A; o_irq_ack = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // State and sticky error registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IF1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_q | (state_d == ST_ERR);
        end
    end

    // Strobes are gated by reset so an abandoned access drops without a clock
    assign o_mem_rd = rd_c & i_rst_n;
    assign o_mem_wr = wr_c & i_rst_n;
    assign o_state  = state_q;
    assign o_err    = err_q;
    assign o_alu_op = alu_c;
    assign o_s1     = s1_c;
    assign o_s2     = s2_c;
    assign o_dest   = dest_c;

endmodule

// File: doc/nlp_sequencer.md
Name: nlp_sequencer

Overview:
Parametrised multi-cycle instruction sequencer for the NLP-16AF core. It decodes IR1/IR2, drives the ALU source/destination selects and memory strobes, and steps a fetch/execute FSM.
- Adds a memory request/acknowledge handshake with wait states and a wait-state timeout error.
- Gives IR2 a distinct register address.
- Routes store instructions through a real write cycle.
- Sits between the register file/ALU datapath and the memory bus interface.

Parameters:
DATA_W, 16, instruction word width (≥16); opcode field is [DATA_W-1 -: 4]
REG_AW, 4, register address width; ZR = all ones
OP_W, 6, ALU opcode width
MAX_WAIT, 15, maximum wait cycles per memory state before timeout (1..255)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_ir1  in  DATA_W  first instruction word
i_ir2  in  DATA_W  second instruction word
i_mem_ack  in  1  memory access complete this cycle
o_state  out  5  current FSM state code
o_err  out  1  sticky error flag
o_alu_op  out  OP_W  ALU opcode
o_s1  out  REG_AW  ALU source 1
o_s2  out  REG_AW  ALU source 2
o_dest  out  REG_AW  ALU destination / register write address
o_mem_rd  out  1  memory read request
o_mem_wr  out  1  memory write request

Behaviour:
- Interface: reset i_rst_n, asynchronous, active-low; clock i_clk. Reset forces state IF1, wait counter 0, err 0.
- Outputs are combinational from state and instruction words.
- Default outputs: alu_op = MOV(0x00), s1 = s2 = dest = ZR, rd = wr = 0.
- Register addresses: IR1 = 1, FLAG = 2, IR3 = 3, IR2 = 4, IP = 0xD, SP = 0xE, ZR = 0xF.
- ALU opcodes: INC = 0x1B, DEC = 0x08, MOV = 0x00.
- Decode, with inst = i_ir1[15:12]:
  - op class when inst[3:2] = 00; push = 0xD, pop = 0xC, call = 0xB, load = 0x8, store = 0x9.
  - ALU opcode = ir1[13:8] for op class, otherwise {00, ir1[11:8]}.
  - ra1 = ir1[REG_AW-1:0], ra2 = ir2[15:12], ra3 = ir2[11:8].
  - im16 when ra2 == 3 or ra3 == 3.
- Memory states are IF1, IF2, IF3, PUSH2, POP1, RD, WR.
  - Each asserts its strobe every cycle until i_mem_ack is sampled high.
  - The state advances on the ack edge.
  - The wait counter increments each non-ack cycle and clears on state change.
  - If the counter reaches MAX_WAIT with no ack, go to ERR.
- Non-memory states last exactly 1 cycle.
- Transitions and outputs:
  - IF1: rd, dest = IR1 → D1.
  - D1: INC IP → PUSH1 (push or call), POP1 (pop), else IF2.
    - call first takes PUSH1/PUSH2 and then fetches IF2.
  - IF2: rd, dest = IR2 → D2.
  - D2: INC IP → IF3 if im16, else EXE.
  - IF3: rd, dest = IR3 → D3.
  - D3: INC IP → EXE.
  - PUSH1: DEC SP → PUSH2.
  - PUSH2: wr, s1 = ra1 → IF2 if call, else IF1.
  - POP1: rd, dest = ra1 → POP2.
  - POP2: INC SP → IF1.
  - EXE: alu_op, s1 = ra2, s2 = ra3, dest = ra1 → RD (load), WR (store), else IF1.
  - RD: rd, dest = ra1 → IF1.
  - WR: wr, s1 = ra1 → IF1.
  - ERR: all defaults, o_err = 1; ERR is terminal until reset.
- An illegal state encoding goes to ERR.
- Reset mid-wait abandons the access; strobes drop asynchronously with reset.
- An ack arriving in a non-memory state is ignored.
- An ack in the same cycle the counter hits MAX_WAIT wins: the state advances with no error.

Optional Feature:
- Macro NLP_SEQ_IRQ_EN.
- When defined, adds input i_irq and output o_irq_ack, plus states IRQ1/IRQ2/IRQ3.
  - In IF1, if i_irq = 1 before the ack, the fetch is abandoned → IRQ1.
  - IRQ1: DEC SP.
  - IRQ2: wr, s1 = IP, handshaked like other memory states.
  - IRQ3: MOV s1 = 0xC → dest = IP, o_irq_ack = 1 for that single cycle → IF1.
- When undefined, the ports and states are absent and behaviour is identical to the base FSM.

Decomposition:
- Package nlp_seq_pkg holds:
  - the state enum;
  - ALU opcode constants;
  - register address constants;
  - instruction class constants.
- Sub-module nlp_seq_wait_timer: wait counter with inputs clear, count, ack and output timeout.

Test Plan:
- ALU op, ack always high: ir1 = 0x0105, ir2 = 0x6700 → state sequence IF1, D1, IF2, D2, EXE, IF1. In EXE: alu_op = 0x01, s1 = 6, s2 = 7, dest = 5.
- Wait states: ir1 = 0x8002, ack held low for 3 cycles in each memory state → each strobe held 4 cycles. RD has dest = 2; o_err stays 0.
- Timeout: ack never asserted in IF1 → ERR entered after 15 wait cycles, o_err = 1; it stays 1 until i_rst_n pulses low.
- Push/call: ir1 = 0xD003 → PUSH1 shows DEC SP; PUSH2 shows wr = 1, s1 = 3; then IF1. With ir1 = 0xB003 the sequence continues to IF2.
- Store with im16: ir1 = 0x9001, ir2 = 0x3100 → IF3/D3 are taken, then EXE, then WR with wr = 1, s1 = 1.
- Reset during RD wait → state IF1 and rd = 0 immediately, with no clock edge required.
